// File: rtl/rf_wb_port.sv
// Writeback producer for the register file's single write port: ALU/load arbitration,
// load extension, return FIFO and pending-load scoreboard. Optional: WB_LOAD_BYPASS_EN.
module rf_wb_port #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    input  logic        mark_valid,
    input  logic [4:0]  mark_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [31:0] busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [4:0]    frd_q  [FIFO_DEPTH];
    logic [31:0]   fdat_q [FIFO_DEPTH];

    logic [31:0] busy_q, busy_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        full, empty, push, pop, byp, fifo_we, clr;
    logic [4:0]  head_rd, clr_rd;
    logic [31:0] head_data, ext_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign ld_ready = ~full;
    assign push    = ld_valid & ~full;
    assign pop     = ~alu_valid & ~empty;

`ifdef WB_LOAD_BYPASS_EN
    assign byp = push & empty & ~alu_valid;
`else
    assign byp = 1'b0;
`endif

    assign fifo_we   = push & ~byp;
    assign head_rd   = frd_q[rptr_q[AW-1:0]];
    assign head_data = fdat_q[rptr_q[AW-1:0]];
    assign clr       = pop | byp;
    assign clr_rd    = pop ? head_rd : ld_rd;

    always_comb begin
        ld_byte = ld_data[7:0];
        case (ld_addr_lo)
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            2'd3:    ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
        ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_funct3)
            3'b000:  ext_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ext_data = {24'h0, ld_byte};
            3'b001:  ext_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ext_data = {16'h0, ld_half};
            default: ext_data = ld_data;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (fifo_we) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);
        if (alu_valid) begin
            we_d    = (alu_rd != 5'd0);
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d    = (head_rd != 5'd0);
            waddr_d = head_rd;
            wdata_d = head_data;
        end else if (byp) begin
            we_d    = (ld_rd != 5'd0);
            waddr_d = ld_rd;
            wdata_d = ext_data;
        end
    end

    // A new mark is applied after the clear so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (clr) begin
            busy_d[clr_rd] = 1'b0;
            if (clr_rd != 5'd0 && !busy_q[clr_rd]) err_d = 1'b1;
        end
        if (mark_valid && mark_rd != 5'd0) begin
            busy_d[mark_rd] = 1'b1;
            if (busy_q[mark_rd]) err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            frd_q[wptr_q[AW-1:0]]  <= ld_rd;
            fdat_q[wptr_q[AW-1:0]] <= ext_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy     = busy_q;
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_rf_wb_port.sv
// Bench for rf_wb_port: directed scenarios plus random traffic against a queue model.
module tb_rf_wb_port;

    localparam int FD = 2;
`ifdef WB_LOAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        mark_valid = 1'b0;
    logic [4:0]  mark_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;

    int total = 0;
    int bad = 0;

    logic [36:0] q[$];
    logic [31:0] m_busy;
    logic        m_err, m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    rf_wb_port #(.FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_data(ld_data), .ld_addr_lo(ld_addr_lo), .ld_funct3(ld_funct3),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .wb_err(wb_err)
    );

    function automatic logic [31:0] ext_m(input logic [31:0] d,
                                          input logic [1:0] lo,
                                          input logic [2:0] f3);
        logic [31:0] b, h;
        int sb, sh;
        sb = 8 * int'(lo);
        sh = 16 * int'(lo[1]);
        b = (d >> sb) & 32'hFF;
        h = (d >> sh) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic idle_in();
        alu_valid = 0; ld_valid = 0; mark_valid = 0;
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0;
        ld_addr_lo = 0; ld_funct3 = 0; mark_rd = 0;
    endtask

    task automatic model_clear();
        q.delete();
        m_busy = 0; m_err = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then step the DUT.
    task automatic tick();
        logic        acc, bp, popped, sel;
        logic [4:0]  srd;
        logic [31:0] sdat, nb;
        logic [36:0] e;
        acc = ld_valid && (q.size() < FD);
        bp = BYP && acc && (q.size() == 0) && !alu_valid;
        sel = 0; popped = 0; srd = 0; sdat = 0;
        nb = m_busy;
        if (alu_valid) begin
            sel = 1; srd = alu_rd; sdat = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            sel = 1; popped = 1; srd = e[36:32]; sdat = e[31:0];
        end else if (bp) begin
            sel = 1; popped = 1; srd = ld_rd;
            sdat = ext_m(ld_data, ld_addr_lo, ld_funct3);
        end
        if (popped) begin
            if (srd != 0 && !m_busy[srd]) m_err = 1;
            nb[srd] = 0;
        end
        if (mark_valid && mark_rd != 0) begin
            if (m_busy[mark_rd]) m_err = 1;
            nb[mark_rd] = 1;
        end
        if (acc && !bp)
            q.push_back({ld_rd, ext_m(ld_data, ld_addr_lo, ld_funct3)});
        nb[0] = 0;
        m_busy = nb;
        m_we = sel && (srd != 0);
        if (sel) begin
            m_waddr = srd; m_wdata = sdat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        #2;
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        idle_in();
        alu_valid = 1; alu_rd = 1; alu_data = 32'hAAAA;
        ld_valid = 1; ld_rd = 12; ld_data = 32'h11; ld_funct3 = 3'b010;
        mark_valid = 1; mark_rd = 12;
        tick();
        ld_rd = 13; ld_data = 32'h22; mark_rd = 13;
        tick();
        ld_valid = 0; mark_valid = 0;
        total++;
        if (busy !== 32'h0000_3000) begin
            bad++; $display("FAIL reset_pre_busy got=%h want=%h", busy, 32'h3000);
        end
        #2;
        rst = 1;
        #1;
        model_clear();
        total++;
        if (rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0) begin
            bad++; $display("FAIL reset_out got=%b/%h/%h want=0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        total++;
        if (busy !== 0 || wb_err !== 0) begin
            bad++; $display("FAIL reset_sb got=%h/%b want=0/0", busy, wb_err);
        end
        total++;
        if (ld_ready !== 1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", ld_ready);
        end
        @(posedge clk);
        #1;
        rst = 0;
        idle_in();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (rf_we !== 0 || busy !== 0) begin
                bad++; $display("FAIL reset_drain got=%b/%h want=0/0", rf_we, busy);
            end
        end
    endtask

    task automatic test_alu();
        idle_in();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        tick();
        total++;
        if (rf_we !== 1 || rf_waddr !== 5 || rf_wdata !== 32'h1234) begin
            bad++; $display("FAIL alu_write got=%b/%0d/%h want=1/5/1234", rf_we, rf_waddr, rf_wdata);
        end
        alu_rd = 0; alu_data = 32'h5555;
        tick();
        total++;
        if (rf_we !== 0) begin
            bad++; $display("FAIL alu_x0 got=%b want=0", rf_we);
        end
        idle_in();
        tick();
    endtask

    task automatic test_extension();
        logic [1:0]  lo [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0};
        logic [2:0]  f3 [5] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010};
        logic [31:0] ex [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF,
                                32'hFFFF80FF, 32'h80FF7F01};
        int n;
        for (int i = 0; i < 5; i++) begin
            idle_in();
            ld_valid = 1; ld_rd = 10; ld_data = 32'h80FF7F01;
            ld_addr_lo = lo[i]; ld_funct3 = f3[i];
            tick();
            idle_in();
            n = 0;
            while (rf_we !== 1 && n < 4) begin
                tick();
                n++;
            end
            total++;
            if (rf_we !== 1 || rf_wdata !== ex[i] || rf_waddr !== 10) begin
                bad++; $display("FAIL ext_%0d got=%b/%h want=1/%h", i, rf_we, rf_wdata, ex[i]);
            end
            total++;
            if (n !== (BYP ? 0 : 1)) begin
                bad++; $display("FAIL ext_lat_%0d got=%0d want=%0d", i, n, BYP ? 0 : 1);
            end
        end
    endtask

    task automatic test_contention();
        idle_in();
        mark_valid = 1; mark_rd = 7;
        tick();
        idle_in();
        ld_valid = 1; ld_rd = 7; ld_data = 32'hCAFE0007; ld_funct3 = 3'b010;
        tick();
        idle_in();
        total++;
        if (rf_we !== BYP || busy[7] !== !BYP) begin
            bad++; $display("FAIL cont_n1 got=%b/%b want=%b/%b", rf_we, busy[7], BYP, !BYP);
        end
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
        tick();
        total++;
        if (rf_we !== 1 || rf_waddr !== 3 || busy[7] !== !BYP) begin
            bad++; $display("FAIL cont_n2 got=%b/%0d/%b want=1/3/%b", rf_we, rf_waddr, busy[7], !BYP);
        end
        alu_data = 32'hB;
        tick();
        idle_in();
        total++;
        if (rf_we !== 1 || rf_waddr !== 3 || rf_wdata !== 32'hB || busy[7] !== !BYP) begin
            bad++; $display("FAIL cont_n3 got=%b/%0d/%h/%b want=1/3/b/%b", rf_we, rf_waddr, rf_wdata, busy[7], !BYP);
        end
        tick();
        total++;
        if (rf_we !== !BYP || rf_waddr !== (BYP ? 5'd3 : 5'd7) || busy[7] !== 0) begin
            bad++; $display("FAIL cont_n4 got=%b/%0d/%b want=%b/%0d/0", rf_we, rf_waddr, busy[7], !BYP, BYP ? 3 : 7);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int k;
        logic [4:0] obs[$];
        k = 0;
        for (int c = 0; c < 14; c++) begin
            idle_in();
            alu_valid = (c < 4); alu_rd = 3; alu_data = c;
            ld_valid = (k < 3); ld_rd = 5'(20 + k); ld_data = k; ld_funct3 = 3'b010;
            #1;
            total++;
            if (ld_ready !== (q.size() < FD)) begin
                bad++; $display("FAIL bp_ready_c%0d got=%b want=%b", c, ld_ready, q.size() < FD);
            end
            if (c == 2) begin
                total++;
                if (ld_ready !== 0) begin
                    bad++; $display("FAIL bp_full got=%b want=0", ld_ready);
                end
            end
            if (ld_valid && q.size() < FD) k++;
            tick();
            if (rf_we === 1 && rf_waddr >= 20) obs.push_back(rf_waddr);
        end
        total++;
        if (obs.size() != 3) begin
            bad++; $display("FAIL bp_count got=%0d want=3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== 5'(20 + i)) begin
                    bad++; $display("FAIL bp_order_%0d got=%0d want=%0d", i, obs[i], 20 + i);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        mark_valid = 1; mark_rd = 9;
        tick();
        idle_in();
        rs1 = 9; rs2 = 0;
        #1;
        total++;
        if (rs1_busy !== 1 || rs2_busy !== 0 || wb_err !== 0) begin
            bad++; $display("FAIL sb_mark got=%b/%b/%b want=1/0/0", rs1_busy, rs2_busy, wb_err);
        end
        mark_valid = 1; mark_rd = 9;
        tick();
        total++;
        if (wb_err !== 1) begin
            bad++; $display("FAIL sb_waw got=%b want=1", wb_err);
        end
        idle_in();
        alu_valid = 1; alu_rd = 1;
        ld_valid = 1; ld_rd = 9; ld_data = 32'h99; ld_funct3 = 3'b010;
        tick();
        idle_in();
        mark_valid = 1; mark_rd = 9;
        tick();
        idle_in();
        #1;
        total++;
        if (busy[9] !== 1 || rs1_busy !== 1 || rf_we !== 1 || rf_waddr !== 9) begin
            bad++; $display("FAIL sb_setwins got=%b/%b/%b/%0d want=1/1/1/9", busy[9], rs1_busy, rf_we, rf_waddr);
        end
        total++;
        if (busy !== m_busy) begin
            bad++; $display("FAIL sb_model got=%h want=%h", busy, m_busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            alu_valid  = ($urandom_range(0, 3) == 0);
            alu_rd     = 5'($urandom);
            alu_data   = $urandom;
            ld_valid   = $urandom_range(0, 1) == 1;
            ld_rd      = 5'($urandom);
            ld_data    = $urandom;
            ld_addr_lo = 2'($urandom);
            ld_funct3  = 3'($urandom);
            mark_valid = ($urandom_range(0, 3) == 0);
            mark_rd    = 5'($urandom);
            rs1        = 5'($urandom);
            rs2        = 5'($urandom);
            #1;
            total++;
            if (ld_ready !== (q.size() < FD) || rs1_busy !== m_busy[rs1] ||
                rs2_busy !== m_busy[rs2]) begin
                bad++;
                $display("FAIL rnd_comb_c%0d got=%b/%b/%b want=%b/%b/%b", c, ld_ready,
                         rs1_busy, rs2_busy, q.size() < FD, m_busy[rs1], m_busy[rs2]);
            end
            tick();
            total++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                bad++;
                $display("FAIL rnd_wr_c%0d got=%b/%0d/%h want=%b/%0d/%h", c, rf_we,
                         rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            total++;
            if (busy !== m_busy || wb_err !== m_err) begin
                bad++;
                $display("FAIL rnd_sb_c%0d got=%h/%b want=%h/%b", c, busy, wb_err, m_busy, m_err);
            end
        end
        idle_in();
    endtask

    initial begin
        model_clear();
        do_reset();
        test_reset();
        test_alu();
        test_extension();
        test_contention();
        do_reset();
        test_backpressure();
        test_scoreboard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
